// File: rtl/rx_buf_arbiter.sv
// rx_buf_arbiter: round-robin share of the rx IQ buffer write port, fill count, irq, overflow.
// Optional feature macro RX_BUF_TAG_EN: prefix each written word with its channel index.
module rx_buf_arbiter #(
   parameter int NCH    = 4,
   parameter int DW     = 32,
   parameter int AW     = 11,
   parameter int THRESH = 1024,
   localparam int CHW   = $clog2(NCH),
`ifdef RX_BUF_TAG_EN
   localparam int WW    = DW + CHW
`else
   localparam int WW    = DW
`endif
) (
   input  logic              adc_clk,
   input  logic              reset_n,
   input  logic              run,
   input  logic [NCH-1:0]    req,
   input  logic [NCH*DW-1:0] din,
   output logic [NCH-1:0]    ack,
   output logic              ram_wr,
   output logic [AW-1:0]     ram_waddr,
   output logic [WW-1:0]     ram_wdata,
   input  logic              host_drain,
   input  logic              clr_ovfl,
   output logic              irq,
   output logic              ovfl,
   output logic [AW:0]       wcnt
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FULL} state_t;

   localparam logic [AW:0]    L_DEPTH = (AW+1)'(1 << AW);
   localparam logic [AW:0]    L_THR   = (AW+1)'(THRESH);
   localparam logic [CHW-1:0] L_LAST  = CHW'(NCH - 1);

   state_t          r_state;
   state_t          w_nxt;
   logic [CHW-1:0]  r_rr;
   logic [CHW-1:0]  w_gidx;
   logic            w_hit;
   logic            w_gnt_en;
   logic [AW:0]     r_count;
   logic [AW:0]     w_cnt_inc;
   logic [AW:0]     w_cnt_nxt;
   logic [AW-1:0]   r_waddr;
   logic            r_wr;
   logic            r_irq;
   logic            r_ovfl;
   logic [WW-1:0]   r_wdata;
   logic [DW-1:0]   w_din;

   assign w_gnt_en = (r_state == S_RUN) && run && (r_count < L_DEPTH);

   // First requester at or after r_rr, wrapping modulo NCH
   always_comb begin
      w_hit  = 1'b0;
      w_gidx = '0;
      for (int i = 0; i < NCH; i++) begin
         if (w_gnt_en && !w_hit && req[(int'(r_rr) + i) % NCH]) begin
            w_hit  = 1'b1;
            w_gidx = CHW'((int'(r_rr) + i) % NCH);
         end
      end
   end

   assign ack   = w_hit ? (NCH'(1) << w_gidx) : '0;
   assign w_din = din[w_gidx*DW +: DW];

   assign w_cnt_inc = r_count + {{AW{1'b0}}, w_hit};

   always_comb begin
      w_cnt_nxt = w_cnt_inc;
      if (host_drain) begin
         w_cnt_nxt = (w_cnt_inc >= L_THR) ? (w_cnt_inc - L_THR) : '0;
      end
   end

   always_comb begin
      w_nxt = r_state;
      unique case (r_state)
         S_IDLE: if (run) w_nxt = S_RUN;
         S_RUN: begin
            if (!run)                      w_nxt = S_IDLE;
            else if (w_cnt_nxt == L_DEPTH) w_nxt = S_FULL;
         end
         S_FULL: begin
            if (!run)                     w_nxt = S_IDLE;
            else if (w_cnt_nxt < L_DEPTH) w_nxt = S_RUN;
         end
         default: w_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge adc_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_rr    <= '0;
         r_count <= '0;
         r_waddr <= '0;
         r_wr    <= 1'b0;
         r_wdata <= '0;
         r_irq   <= 1'b0;
         r_ovfl  <= 1'b0;
      end else begin
         r_state <= w_nxt;
         r_wr    <= w_hit;
         r_irq   <= (r_count >= L_THR);
         if (w_hit) begin
`ifdef RX_BUF_TAG_EN
            r_wdata <= {w_gidx, w_din};
`else
            r_wdata <= w_din;
`endif
         end
         // A write registered before run fell still lands at the old address
         if (!run) begin
            r_waddr <= '0;
            r_count <= '0;
            r_rr    <= '0;
         end else begin
            r_count <= w_cnt_nxt;
            if (r_wr)  r_waddr <= r_waddr + 1'b1;
            if (w_hit) r_rr <= (w_gidx == L_LAST) ? '0 : w_gidx + 1'b1;
         end
         if ((r_state == S_FULL) && (|req)) r_ovfl <= 1'b1;
         else if (clr_ovfl)                 r_ovfl <= 1'b0;
      end
   end

   assign ram_wr    = r_wr;
   assign ram_waddr = r_waddr;
   assign ram_wdata = r_wdata;
   assign irq       = r_irq;
   assign ovfl      = r_ovfl;
   assign wcnt      = r_count;

endmodule
